alu_share_arbiter: RTL and testbench

Arbitrates one shared 32-bit ALU instance between two requesters (port 0: execute stage, port 1: branch/address helper) with a valid/ready request handshake and a valid/ready response handshake. Round-robin grant, registered operands, one operation in flight. Sits between the requesters and the ALU's Src_A/Src_B/ALUcontrol inputs and ALUResult/zero outputs.

---
 rtl/alu_share_arbiter.sv | 105 ++++++++++
 tb/tb_alu_share_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between an execute-stage requester (port 0) and a branch/address helper (port 1).
// Round-robin grant, registered operands, a single operation in flight at a time.
module alu_share_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_A,
   input  logic [WIDTH-1:0] req0_B,
   input  logic [2:0]       req0_ctrl,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_A,
   input  logic [WIDTH-1:0] req1_B,
   input  logic [2:0]       req1_ctrl,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic [WIDTH-1:0] alu_A,
   output logic [WIDTH-1:0] alu_B,
   output logic [2:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [2:0]       op_ctrl;
   logic [WIDTH-1:0] res_q;
   logic             zero_q;
   logic             grant_id;
   logic             last_grant;
   logic             grant;
   logic             accept;
   logic             rsp_done;

   // On a tie the port that was not served last wins.
   always_comb begin
      grant = ~last_grant;
      if (req0_valid && !req1_valid) begin
         grant = 1'b0;
      end else if (req1_valid && !req0_valid) begin
         grant = 1'b1;
      end
   end

   assign req0_ready = (state == IDLE) && !reset && req0_valid && !grant;
   assign req1_ready = (state == IDLE) && !reset && req1_valid && grant;
   assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
   assign rsp_done   = grant_id ? rsp1_ready : rsp0_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         op_a       <= '0;
         op_b       <= '0;
         op_ctrl    <= 3'b000;
         res_q      <= '0;
         zero_q     <= 1'b0;
         grant_id   <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_a     <= grant ? req1_A : req0_A;
                  op_b     <= grant ? req1_B : req0_B;
                  op_ctrl  <= grant ? req1_ctrl : req0_ctrl;
                  grant_id <= grant;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               res_q      <= alu_result;
               zero_q     <= alu_zero;
               last_grant <= grant_id;
               state      <= RESP;
            end
            RESP: begin
               if (rsp_done) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rsp0_valid = (state == RESP) && !grant_id;
   assign rsp1_valid = (state == RESP) && grant_id;
   assign rsp_result = res_q;
   assign rsp_zero   = zero_q;
   assign alu_A      = op_a;
   assign alu_B      = op_b;
   assign alu_ctrl   = op_ctrl;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed and randomized transactions checked against
// a round-robin/ALU reference model, with a behavioural ALU attached to the shared port.
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_A, req0_B, req1_A, req1_B;
   logic [2:0]  req0_ctrl, req1_ctrl;
   logic        rsp0_valid, rsp1_valid;
   logic        rsp0_ready, rsp1_ready;
   logic [31:0] rsp_result;
   logic        rsp_zero;
   logic [31:0] alu_A, alu_B, alu_result;
   logic [2:0]  alu_ctrl;
   logic        alu_zero;

   int checks = 0;
   int errors = 0;
   bit model_last = 1'b1;

   always #5 clk = ~clk;

   alu_share_arbiter #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_A(req0_A), .req0_B(req0_B), .req0_ctrl(req0_ctrl),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_A(req1_A), .req1_B(req1_B), .req1_ctrl(req1_ctrl),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero),
      .alu_A(alu_A), .alu_B(alu_B), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_zero(alu_zero)
   );

   function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] c);
      case (c)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return a + b;
         3'b110:  return a - b;
         default: return a;
      endcase
   endfunction

   assign alu_result = alu_model(alu_A, alu_B, alu_ctrl);
   assign alu_zero   = (alu_ctrl == 3'b110) && (alu_A == alu_B);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_last = 1'b1;
   endtask

   // One transaction: the model picks the winner, the loser (if any) keeps valid high throughout.
   task automatic transact(input bit v0, input bit v1,
                           input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] c0,
                           input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] c1,
                           input int hold);
      bit          win;
      logic [31:0] ea, eb, er;
      logic [2:0]  ec;
      logic        ez;
      if (v0 && v1) win = ~model_last;
      else          win = v1;
      ea = win ? a1 : a0;
      eb = win ? b1 : b0;
      ec = win ? c1 : c0;
      er = (ec == 3'b000) ? (ea & eb) :
           (ec == 3'b001) ? (ea | eb) :
           (ec == 3'b010) ? (ea + eb) :
           (ec == 3'b110) ? (ea - eb) : ea;
      ez = (ec == 3'b110) && (ea == eb);

      @(negedge clk);
      req0_valid = v0; req0_A = a0; req0_B = b0; req0_ctrl = c0;
      req1_valid = v1; req1_A = a1; req1_B = b1; req1_ctrl = c1;
      #1;
      check("winner_ready", win ? req1_ready : req0_ready, 1);
      check("loser_ready", win ? req0_ready : req1_ready, 0);
      @(posedge clk);
      @(negedge clk);
      if (win) req1_valid = 1'b0; else req0_valid = 1'b0;
      if (win) rsp1_ready = (hold == 0); else rsp0_ready = (hold == 0);
      check("exec_alu_A", alu_A, ea);
      check("exec_alu_B", alu_B, eb);
      check("exec_alu_ctrl", {29'd0, alu_ctrl}, {29'd0, ec});
      check("exec_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
      check("exec_ready", {req1_ready, req0_ready}, 0);
      @(posedge clk);
      @(negedge clk);
      check("rsp_valid", {rsp1_valid, rsp0_valid}, win ? 2 : 1);
      check("rsp_result", rsp_result, er);
      check("rsp_zero", rsp_zero, ez);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("hold_valid", {rsp1_valid, rsp0_valid}, win ? 2 : 1);
         check("hold_result", rsp_result, er);
         check("hold_zero", rsp_zero, ez);
         check("hold_ready", {req1_ready, req0_ready}, 0);
      end
      if (win) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("done_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
      check("idle_alu_A", alu_A, ea);
      check("idle_alu_ctrl", {29'd0, alu_ctrl}, {29'd0, ec});
      req0_valid = 1'b0; req1_valid = 1'b0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      model_last = win;
   endtask

   initial begin
      logic [31:0] ra, rb;
      reset = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_A = '0; req0_B = '0; req0_ctrl = '0;
      req1_A = '0; req1_B = '0; req1_ctrl = '0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_ready", {req1_ready, req0_ready}, 0);
      check("reset_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
      check("reset_alu_A", alu_A, 0);
      check("reset_alu_B", alu_B, 0);
      check("reset_alu_ctrl", {29'd0, alu_ctrl}, 0);
      check("reset_result", rsp_result, 0);
      check("reset_zero", rsp_zero, 0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      reset = 1'b0;

      transact(1, 0, 32'h5, 32'h3, 3'b010, 0, 0, 0, 0);
      transact(0, 1, 0, 0, 0, 32'h7, 32'h7, 3'b110, 0);
      transact(0, 1, 0, 0, 0, 32'h8, 32'h3, 3'b110, 0);
      transact(1, 1, 32'h1234, 32'h1111, 3'b010, 32'h9, 32'h9, 3'b110, 5);
      transact(0, 1, 0, 0, 0, 32'hDEADBEEF, 32'h1, 3'b111, 0);

      apply_reset();
      transact(1, 1, 32'hF0F0, 32'h0FF0, 3'b000, 32'h1, 32'h2, 3'b001, 0);
      transact(0, 1, 0, 0, 0, 32'h1, 32'h2, 3'b001, 0);
      transact(1, 1, 32'hAA, 32'h55, 3'b001, 32'h3, 32'h4, 3'b010, 1);

      // Reset arriving while the operation is in EXEC drops it without a response.
      @(negedge clk);
      req0_valid = 1'b1; req0_A = 32'hCAFE; req0_B = 32'h1; req0_ctrl = 3'b010;
      rsp0_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req0_valid = 1'b0;
      reset = 1'b1;
      #1;
      check("rst_exec_alu_A", alu_A, 0);
      check("rst_exec_alu_B", alu_B, 0);
      check("rst_exec_alu_ctrl", {29'd0, alu_ctrl}, 0);
      check("rst_exec_result", rsp_result, 0);
      @(negedge clk);
      reset = 1'b0;
      model_last = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_no_rsp", {rsp1_valid, rsp0_valid}, 0);
      end
      rsp0_ready = 1'b0;
      transact(1, 1, 32'h10, 32'h10, 3'b110, 32'h2, 32'h1, 3'b110, 0);

      for (int n = 0; n < 20; n++) begin
         bit v0, v1;
         v0 = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1));
         if (!v0 && !v1) v0 = 1'b1;
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
         transact(v0, v1, ra, rb, 3'($urandom_range(0, 7)),
                  rb, ra, 3'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
